// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel-in / window-out handshake bundle for conv_window_gen.
// m_last exists only when WIN_LAST_EN is defined.
interface conv_window_gen_if #(
    parameter int DWIDTH_DAT = 12,
    parameter int SLICE      = 3
);
    logic                              s_valid;
    logic                              s_ready;
    logic                              s_sof;
    logic [DWIDTH_DAT-1:0]             s_data;
    logic                              m_valid;
    logic                              m_ready;
    logic [SLICE*SLICE*DWIDTH_DAT-1:0] m_window;
`ifdef WIN_LAST_EN
    logic                              m_last;
`endif

    modport slave (
        input  s_valid, s_sof, s_data, m_ready,
        output s_ready, m_valid, m_window
`ifdef WIN_LAST_EN
        , output m_last
`endif
    );

    modport master (
        output s_valid, s_sof, s_data, m_ready,
        input  s_ready, m_valid, m_window
`ifdef WIN_LAST_EN
        , input m_last
`endif
    );
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming SLICE x SLICE sliding-window generator over raster RGB444 pixels.
// Optional WIN_LAST_EN adds m_last flagging the final window of each frame.
module conv_window_gen #(
    parameter int DWIDTH_DAT = 12,
    parameter int SLICE      = 3,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 48
) (
    input logic              clk,
    input logic              rst_n,
    conv_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(SLICE - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(SLICE - 1);

    typedef logic [DWIDTH_DAT-1:0] pix_t;

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          m_valid_q, m_valid_d;
    logic          accept, complete, col_wrap;
    pix_t          win_q [SLICE][SLICE];
    pix_t          win_d [SLICE][SLICE];
    pix_t          lb_q [SLICE-1][IMG_W];
    pix_t          col_pix [SLICE];

    assign bus.s_ready = ~m_valid_q | bus.m_ready;
    assign accept      = bus.s_valid & bus.s_ready;
    assign cur_col     = bus.s_sof ? '0 : col_q;
    assign cur_row     = bus.s_sof ? '0 : row_q;
    assign col_wrap    = cur_col == COL_MAX;
    assign complete    = cur_col >= COL_FIRST && cur_row >= ROW_FIRST;
    assign col_d       = !accept ? col_q : col_wrap ? '0 : cur_col + 1'b1;
    assign row_d       = !accept ? row_q : !col_wrap ? cur_row : cur_row == ROW_MAX ? '0 : cur_row + 1'b1;
    assign m_valid_d   = accept ? complete : bus.m_ready ? 1'b0 : m_valid_q;

    // Column entering the window: oldest line on top, live pixel at the bottom.
    always_comb begin
        for (int k = 0; k < SLICE - 1; k++) col_pix[k] = lb_q[k][cur_col];
        col_pix[SLICE-1] = bus.s_data;
    end

    always_comb begin
        win_d = win_q;
        if (accept)
            for (int r = 0; r < SLICE; r++) begin
                for (int c = 0; c < SLICE - 1; c++) win_d[r][c] = win_q[r][c+1];
                win_d[r][SLICE-1] = col_pix[r];
            end
    end

    // Line buffers age one line per pass: each slot takes the value from the buffer below it.
    always_ff @(posedge clk)
        if (accept)
            for (int k = 0; k < SLICE - 1; k++) lb_q[k][cur_col] <= col_pix[k+1];

    always_ff @(posedge clk)
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            m_valid_q <= 1'b0;
            win_q     <= '{default: '0};
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            m_valid_q <= m_valid_d;
            win_q     <= win_d;
        end

    // The window regs only move on accept, which cannot happen while a window is stalled.
    for (genvar r = 0; r < SLICE; r++)
        for (genvar c = 0; c < SLICE; c++)
            assign bus.m_window[DWIDTH_DAT*(r*SLICE+c) +: DWIDTH_DAT] = win_q[r][c];

    assign bus.m_valid = m_valid_q;

`ifdef WIN_LAST_EN
    logic m_last_q, m_last_d;

    assign m_last_d = accept ? col_wrap && cur_row == ROW_MAX : bus.m_ready ? 1'b0 : m_last_q;

    always_ff @(posedge clk)
        if (!rst_n) m_last_q <= 1'b0;
        else        m_last_q <= m_last_d;

    assign bus.m_last = m_last_q;
`endif
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed self-checking bench for conv_window_gen (SLICE=3, 8x6 image).
module tb_conv_window_gen;
    localparam int DW = 12;
    localparam int S  = 3;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int WW = S * S * DW;
    localparam int NWIN = (W - S + 1) * (H - S + 1);

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [WW-1:0] got_q[$];
    bit            last_q[$];

    conv_window_gen_if #(.DWIDTH_DAT(DW), .SLICE(S)) bus ();

    conv_window_gen #(.DWIDTH_DAT(DW), .SLICE(S), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Records every window that will be handshaken at the following rising edge.
    always @(negedge clk)
        if (rst_n && bus.m_valid && bus.m_ready) begin
            got_q.push_back(bus.m_window);
`ifdef WIN_LAST_EN
            last_q.push_back(bus.m_last);
`else
            last_q.push_back(1'b0);
`endif
        end

    function automatic logic [WW-1:0] win9(input int e [9]);
        logic [WW-1:0] w;
        for (int i = 0; i < 9; i++) w[DW*i +: DW] = DW'(e[i]);
        return w;
    endfunction

    // Window ending at pixel (c,r) where pixel value = r*W + c.
    function automatic logic [WW-1:0] exp_win(input int c, input int r);
        logic [WW-1:0] w;
        for (int rr = 0; rr < S; rr++)
            for (int cc = 0; cc < S; cc++)
                w[DW*(rr*S+cc) +: DW] = DW'((r - S + 1 + rr) * W + (c - S + 1 + cc));
        return w;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic send(input int v, input bit sof);
        int n;
        bit ok;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = DW'(v);
        bus.s_sof   = sof;
        do begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout pixel %0d never accepted", v);
        end
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    task automatic send_range(input int first, input int last, input bit sof_first);
        for (int i = first; i <= last; i++) send(i, sof_first && i == first);
    endtask

    task automatic check_frames(input int frames, input string tag);
        checks++;
        if (got_q.size() != NWIN * frames) begin
            errors++;
            $display("FAIL %s_count got %0d windows expected %0d", tag, got_q.size(), NWIN * frames);
        end
        for (int i = 0; i < got_q.size() && i < NWIN * frames; i++) begin
            int k, r, c;
            k = i % NWIN;
            r = k / (W - S + 1) + S - 1;
            c = k % (W - S + 1) + S - 1;
            checks++;
            if (got_q[i] !== exp_win(c, r)) begin
                errors++;
                $display("FAIL %s_win[%0d] got %h expected %h", tag, i, got_q[i], exp_win(c, r));
            end
`ifdef WIN_LAST_EN
            checks++;
            if (last_q[i] !== (k == NWIN - 1)) begin
                errors++;
                $display("FAIL %s_last[%0d] got %0b expected %0b", tag, i, last_q[i], k == NWIN - 1);
            end
`endif
        end
        got_q.delete();
        last_q.delete();
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b expected 0", bus.m_valid); end
        checks++;
        if (bus.m_window !== '0) begin errors++; $display("FAIL reset_m_window got %h expected 0", bus.m_window); end
        checks++;
        if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b expected 1", bus.s_ready); end
`ifdef WIN_LAST_EN
        checks++;
        if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b expected 0", bus.m_last); end
`endif
    endtask

    task automatic test_first_window();
        reset_dut();
        got_q.delete();
        last_q.delete();
        send_range(0, 17, 1'b1);
        checks++;
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL first_early got m_valid %b expected 0", bus.m_valid); end
        send(18, 1'b0);
        checks++;
        if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b expected 1", bus.m_valid); end
        checks++;
        if (bus.m_window !== win9('{0, 1, 2, 8, 9, 10, 16, 17, 18}))
            begin errors++; $display("FAIL first_window got %h expected %h", bus.m_window, win9('{0, 1, 2, 8, 9, 10, 16, 17, 18})); end
        send_range(19, 47, 1'b0);
        idle(3);
        check_frames(1, "frame");
        // Second frame without s_sof relies on the counters wrapping by themselves.
        send_range(0, 47, 1'b0);
        idle(3);
        check_frames(1, "nosof");
    endtask

    task automatic test_line_wrap();
        send_range(0, 47, 1'b1);
        idle(3);
        checks++;
        if (got_q.size() < 7) begin
            errors++;
            $display("FAIL wrap_count got %0d windows expected at least 7", got_q.size());
        end else begin
            checks++;
            if (got_q[5] !== win9('{5, 6, 7, 13, 14, 15, 21, 22, 23}))
                begin errors++; $display("FAIL wrap_row_end got %h expected %h", got_q[5], win9('{5, 6, 7, 13, 14, 15, 21, 22, 23})); end
            checks++;
            if (got_q[6] !== win9('{8, 9, 10, 16, 17, 18, 24, 25, 26}))
                begin errors++; $display("FAIL wrap_row_start got %h expected %h", got_q[6], win9('{8, 9, 10, 16, 17, 18, 24, 25, 26})); end
        end
        check_frames(1, "wrap");
    endtask

    task automatic test_backpressure();
        reset_dut();
        got_q.delete();
        last_q.delete();
        fork
            send_range(0, 47, 1'b1);
            begin
                logic [WW-1:0] held;
                int n;
                n = 0;
                do begin @(negedge clk); n++; end while (!bus.m_valid && n < 200);
                checks++;
                if (!bus.m_valid) begin
                    errors++;
                    $display("FAIL bp_wait m_valid never rose");
                end else begin
                    @(posedge clk);
                    #1;
                    bus.m_ready = 1'b0;
                    held = bus.m_window;
                    repeat (5) begin
                        @(negedge clk);
                        checks++;
                        if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready got %b expected 0", bus.s_ready); end
                        checks++;
                        if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_valid got %b expected 1", bus.m_valid); end
                        checks++;
                        if (bus.m_window !== held) begin errors++; $display("FAIL bp_m_window got %h expected %h", bus.m_window, held); end
                    end
                    @(posedge clk);
                    #1;
                    bus.m_ready = 1'b1;
                end
            end
        join
        idle(3);
        check_frames(1, "bp");
    endtask

    task automatic test_sof_mid();
        reset_dut();
        got_q.delete();
        last_q.delete();
        send_range(0, 12, 1'b1);
        send_range(0, 17, 1'b1);
        checks++;
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL sof_early got m_valid %b expected 0", bus.m_valid); end
        send(18, 1'b0);
        checks++;
        if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL sof_valid got %b expected 1", bus.m_valid); end
        checks++;
        if (bus.m_window !== win9('{0, 1, 2, 8, 9, 10, 16, 17, 18}))
            begin errors++; $display("FAIL sof_window got %h expected %h", bus.m_window, win9('{0, 1, 2, 8, 9, 10, 16, 17, 18})); end
        send_range(19, 47, 1'b0);
        idle(3);
        check_frames(1, "sof");
    endtask

    task automatic test_reset_mid();
        reset_dut();
        send_range(0, 29, 1'b1);
        checks++;
        if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got m_valid %b expected 1", bus.m_valid); end
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        checks++;
        if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rmid_m_valid got %b expected 0", bus.m_valid); end
        checks++;
        if (bus.m_window !== '0) begin errors++; $display("FAIL rmid_m_window got %h expected 0", bus.m_window); end
        got_q.delete();
        last_q.delete();
        send_range(0, 47, 1'b1);
        idle(3);
        check_frames(1, "rmid");
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        test_reset();
        test_first_window();
        test_line_wrap();
        test_backpressure();
        test_sof_mid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
